// File: rtl/sc_bitstream_decoder_pkg.sv
// Shared types for the stochastic bitstream decoder: FSM state encoding and window-length helper.
package sc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } sc_dec_state_t;

   function automatic int win_len(input int inwd);
      return 1 << inwd;
   endfunction

endpackage

// File: rtl/sc_bitstream_decoder_ones_counter.sv
// Clearable up-counter of sampled '1' bits; clear wins over inc, one-cycle update.
module sc_ones_counter #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Counts ones over 2^INWD enabled cycles; result valid the cycle after the last bit.
// binOut/binValid held in DONE until outReady; start in DONE is ignored until consumed.
module sc_bitstream_decoder
   import sc_pkg::*;
#(
   parameter int INWD       = 8,
   parameter bit CONTINUOUS = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          start,
   input  logic          bitIn,
   input  logic          outReady,
   output logic [INWD:0] binOut,
   output logic          binValid,
   output logic          busy
);

   localparam logic [INWD-1:0] CYC_LAST = INWD'(win_len(INWD) - 1);

   sc_dec_state_t state;
   sc_dec_state_t state_nxt;

   logic [INWD-1:0] cyc_cnt;
   logic [INWD:0]   ones_cnt;
   logic            sample;
   logic            last_bit;
   logic            clear;

   // A restart pulse in ACCUM discards the bit of that cycle, so it suppresses sampling.
   always_comb begin
      sample   = (state == ACCUM) && enable && !start;
      last_bit = sample && (cyc_cnt == CYC_LAST);
      clear    = ((state == IDLE)  && (start || CONTINUOUS))
              || ((state == ACCUM) && start)
              || ((state == DONE)  && outReady && (start || CONTINUOUS));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start || CONTINUOUS) state_nxt = ACCUM;
         ACCUM:   if (last_bit) state_nxt = DONE;
         DONE:    if (outReady) state_nxt = (start || CONTINUOUS) ? ACCUM : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == ACCUM);
      binValid = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt <= '0;
      end else if (clear) begin
         cyc_cnt <= '0;
      end else if (sample) begin
         cyc_cnt <= cyc_cnt + INWD'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         binOut <= '0;
      end else if (last_bit) begin
         binOut <= ones_cnt + (INWD+1)'(bitIn);
      end
   end

   sc_ones_counter #(
      .W (INWD + 1)
   ) u_ones_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .inc   (sample && bitIn),
      .count (ones_cnt)
   );

endmodule

// File: doc/sc_bitstream_decoder.md
Name: sc_bitstream_decoder

Overview:
Stochastic-to-binary converter for the receiving end of a stochastic bitstream. The transmitting end is a binary-to-stochastic generator: a Sobol/LFSR RNG feeding a comparator. This block counts the '1' bits of a unipolar bitstream over a fixed window of 2^INWD enabled cycles. It then presents the count as a binary value, using a valid/ready handshake. It sits after stochastic arithmetic units and closes the loop for accuracy measurement and for readback.

Parameters:
INWD, 8, log2 of window length; window = 2^INWD enabled cycles; legal range 3..10.
CONTINUOUS, 0, 1 = after a result is consumed, automatically start the next window without a start pulse.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active low
enable  input  1  qualifies bitIn; counters advance only when high
start  input  1  single-cycle request to begin a new window
bitIn  input  1  stochastic bitstream bit, sampled when enable=1 in ACCUM
outReady  input  1  consumer accepts binOut when binValid=1
binOut  output  INWD+1  count of ones in the last completed window (0..2^INWD)
binValid  output  1  binOut holds a completed result
busy  output  1  window accumulation in progress

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; binOut=0, binValid=0, busy=0.
  - Internal cycCnt (INWD bits) = 0; onesCnt (INWD+1 bits) = 0.
  - Reset mid-window discards all partial state.
- States:
  - IDLE:
    - start=1 -> ACCUM, counters cleared.
    - If CONTINUOUS=1, go to ACCUM one cycle after reset release without needing start.
  - ACCUM (busy=1):
    - Each cycle with enable=1: onesCnt += bitIn; cycCnt += 1.
    - enable=0: all counters hold; bitIn is ignored.
    - When enable=1 and cycCnt == 2^INWD-1: binOut <= onesCnt + bitIn; binValid <= 1; -> DONE.
    - start=1 in ACCUM: restart. Counters clear, the bit in that cycle is discarded, stay in ACCUM. A restart has priority over completion in the same cycle.
  - DONE (binValid=1, busy=0):
    - binOut is held stable until the handshake completes.
    - outReady=1 -> binValid <= 0 and -> IDLE.
    - In CONTINUOUS mode, or if start=1 in the same cycle, go -> ACCUM with counters cleared.
    - start with outReady=0 in DONE is ignored (result must be consumed first).
- Latency: binValid rises on the clock edge that samples the 2^INWD-th enabled bit, i.e. it is visible the cycle after that bit.
- Width: onesCnt must reach 2^INWD (all ones), so it is INWD+1 bits. cycCnt wraps naturally from 2^INWD-1 to 0 on completion.
- binOut keeps its last value in IDLE/ACCUM. It updates only on window completion.
- bitIn is X-tolerant when enable=0 or the state is not ACCUM.

Decomposition:
- Shared package sc_pkg:
  - typedef enum logic [1:0] {IDLE, ACCUM, DONE} sc_dec_state_t.
  - Localparam helper for window length (1 << INWD).
- One sub-module, sc_ones_counter:
  - Parameterised INWD+1-bit up-counter.
  - Inputs clear/inc; the inc input is driven by enable & bitIn.
  - The top-level FSM owns cycCnt and the handshake.

Test Plan:
- INWD=8, start, then 256 enabled cycles with bitIn=1 -> binValid=1 one cycle after the last bit, binOut=256; outReady=1 -> binValid=0, IDLE.
- bitIn alternating 1/0 for 256 cycles, with enable deasserted for 40 random cycles in the middle -> binOut=128, completion delayed by exactly 40 cycles.
- Drive from a Sobol RNG (dimension 1) compared against a constant 77 -> binOut=77 exactly, since Sobol covers each 8-bit value once per window.
- Hold outReady=0 for 20 cycles after completion while bitIn toggles -> binOut stable, binValid held. Then start+outReady in the same cycle -> directly to ACCUM, with next result independent of the old one.
- start re-asserted at cycle 100 of a window (all ones) -> old partial discarded, binOut=256 after 256 further enabled cycles, no intermediate binValid.
- rst_n pulsed low mid-window (asynchronously, between edges) -> outputs 0 immediately. CONTINUOUS=1: new window starts unprompted; all-zero input yields binOut=0 with binValid.
